conved_maxpool_reader: RTL and testbench

//   Downstream consumer of the conved feature-map memory (CON_SIZE x CON_SIZE, filled by the conv write counter).

---
 rtl/conved_maxpool_reader_pkg.sv | 17 +
 rtl/conved_maxpool_reader_if.sv | 32 +++
 rtl/conved_maxpool_reader_max2.sv | 12 +
 rtl/conved_maxpool_reader.sv | 144 ++++++++++++++
 tb/tb_conved_maxpool_reader.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/conved_maxpool_reader_pkg.sv
// Shared CNN types and sizing constants for the conved-map pooling stage.
package cnn_pkg;

    localparam int DATA_W    = 16;
    localparam int CON_SIZE  = 4;
    localparam int CON_ADDR  = 2;
    localparam int POOL_SIZE = CON_SIZE / 2;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        DRAIN,
        OUT,
        DONE
    } pool_state_t;

endpackage

// File: rtl/conved_maxpool_reader_if.sv
// Bundle of the conved-memory read port, the pooled valid/ready output and status.
interface conved_maxpool_reader_if #(
    parameter int CON_ADDR = cnn_pkg::CON_ADDR,
    parameter int DATA_W   = cnn_pkg::DATA_W
);

    logic                       start;
    logic                       rd_en;
    logic        [CON_ADDR-1:0] rd_row;
    logic        [CON_ADDR-1:0] rd_col;
    logic signed [DATA_W-1:0]   rd_data;
    logic signed [DATA_W-1:0]   pool_data;
    logic        [CON_ADDR-2:0] pool_row;
    logic        [CON_ADDR-2:0] pool_col;
    logic                       pool_valid;
    logic                       pool_ready;
    logic                       busy;
    logic                       done;

    modport master (
        input  start, rd_data, pool_ready,
        output rd_en, rd_row, rd_col, pool_data, pool_row, pool_col,
               pool_valid, busy, done
    );

    modport slave (
        output start, rd_data, pool_ready,
        input  rd_en, rd_row, rd_col, pool_data, pool_row, pool_col,
               pool_valid, busy, done
    );

endinterface

// File: rtl/conved_maxpool_reader_max2.sv
// Two-input signed maximum; on a tie the b operand (the running max) is kept.
module max2_signed #(
    parameter int DATA_W = 16
) (
    input  logic signed [DATA_W-1:0] i_a,
    input  logic signed [DATA_W-1:0] i_b,
    output logic signed [DATA_W-1:0] o_y
);

    assign o_y = (i_a > i_b) ? i_a : i_b;

endmodule

// File: rtl/conved_maxpool_reader.sv
// Walks the conved map in 2x2 windows, one read per cycle, and emits the signed
// max of each window on a valid/ready port.
module conved_maxpool_reader #(
    parameter int CON_SIZE = cnn_pkg::CON_SIZE,
    parameter int CON_ADDR = cnn_pkg::CON_ADDR,
    parameter int DATA_W   = cnn_pkg::DATA_W
) (
    input  logic                    clk,
    input  logic                    reset,
    conved_maxpool_reader_if.master bus
);

    import cnn_pkg::*;

    localparam int                POOL_W   = CON_ADDR - 1;
    localparam logic [POOL_W-1:0] LAST_WIN = POOL_W'(CON_SIZE / 2 - 1);

    pool_state_t               r_state;
    pool_state_t               w_next_state;
    logic        [POOL_W-1:0]  r_win_r;
    logic        [POOL_W-1:0]  r_win_c;
    logic        [1:0]         r_k;
    logic        [1:0]         r_k_d;
    logic                      r_rd_vld_d;
    logic signed [DATA_W-1:0]  r_acc;
    logic signed [DATA_W-1:0]  w_max;
    logic                      w_last_win;

    assign w_last_win = (r_win_r == LAST_WIN) && (r_win_c == LAST_WIN);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: the default assignment first keeps this combinational block from
    // inferring a latch on paths that do not assign the signal.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE:    if (bus.start) w_next_state = RD;
            RD:      if (r_k == 2'd3) w_next_state = DRAIN;
            DRAIN:   w_next_state = OUT;
            OUT:     if (bus.pool_ready) w_next_state = w_last_win ? DONE : RD;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Read address is the window origin doubled plus the k offset: TL, TR, BL, BR.
    always_comb begin
        bus.rd_en      = 1'b0;
        bus.rd_row     = '0;
        bus.rd_col     = '0;
        bus.pool_valid = 1'b0;
        bus.pool_data  = '0;
        bus.pool_row   = '0;
        bus.pool_col   = '0;
        bus.busy       = 1'b0;
        bus.done       = 1'b0;
        unique case (r_state)
            RD: begin
                bus.rd_en  = 1'b1;
                bus.rd_row = {r_win_r, r_k[1]};
                bus.rd_col = {r_win_c, r_k[0]};
                bus.busy   = 1'b1;
            end
            DRAIN: begin
                bus.busy = 1'b1;
            end
            OUT: begin
                bus.pool_valid = 1'b1;
                bus.pool_data  = r_acc;
                bus.pool_row   = r_win_r;
                bus.pool_col   = r_win_c;
                bus.busy       = 1'b1;
            end
            DONE: begin
                bus.done = 1'b1;
                bus.busy = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_win_r <= '0;
            r_win_c <= '0;
            r_k     <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_win_r <= '0;
                        r_win_c <= '0;
                        r_k     <= '0;
                    end
                end
                RD: r_k <= r_k + 2'd1;
                OUT: begin
                    if (bus.pool_ready && !w_last_win) begin
                        if (r_win_c == LAST_WIN) begin
                            r_win_c <= '0;
                            r_win_r <= r_win_r + POOL_W'(1);
                        end else begin
                            r_win_c <= r_win_c + POOL_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    max2_signed #(
        .DATA_W (DATA_W)
    ) u_max2 (
        .i_a (bus.rd_data),
        .i_b (r_acc),
        .o_y (w_max)
    );

    // Delayed strobe and k tag mark which cycle carries which window element.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_vld_d <= 1'b0;
            r_k_d      <= '0;
            r_acc      <= '0;
        end else begin
            r_rd_vld_d <= (r_state == RD);
            r_k_d      <= r_k;
            if (r_rd_vld_d) begin
                r_acc <= (r_k_d == 2'd0) ? bus.rd_data : w_max;
            end
        end
    end

endmodule

// File: tb/tb_conved_maxpool_reader.sv
// Scoreboard bench: stimulus pushes expected windows, a negedge monitor pops and compares.
module tb_conved_maxpool_reader;

    import cnn_pkg::*;

    localparam int CS = 4;
    localparam int CA = 2;
    localparam int DW = 16;

    typedef struct {
        int data;
        int row;
        int col;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    conved_maxpool_reader_if #(.CON_ADDR(CA), .DATA_W(DW)) bus ();

    conved_maxpool_reader #(
        .CON_SIZE (CS),
        .CON_ADDR (CA),
        .DATA_W   (DW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic signed [DW-1:0] mem [CS][CS];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_done   = 0;
    int   n_rd     = 0;
    bit   stall_mode = 1'b0;

    // Memory model: data one cycle after rd_en, junk on every other cycle.
    always @(posedge clk) begin
        if (bus.rd_en) bus.rd_data <= mem[bus.rd_row][bus.rd_col];
        else           bus.rd_data <= 16'sh7FFF;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor
    bit                   stall_seen = 1'b0;
    logic signed [DW-1:0] held_data;
    logic        [CA-2:0] held_row;
    logic        [CA-2:0] held_col;

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            stall_seen = 1'b0;
        end else begin
            if (bus.done)  n_done++;
            if (bus.rd_en) n_rd++;
            if (bus.pool_valid) begin
                check("rd_en_in_out", int'(bus.rd_en), 0);
                if (stall_seen) begin
                    check("stall_data", int'(bus.pool_data), int'(held_data));
                    check("stall_row", int'(bus.pool_row), int'(held_row));
                    check("stall_col", int'(bus.pool_col), int'(held_col));
                end
                if (bus.pool_ready) begin
                    stall_seen = 1'b0;
                    if (sb.size() == 0) begin
                        check("unexpected_pool", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("pool_data", int'(bus.pool_data), e.data);
                        check("pool_row", int'(bus.pool_row), e.row);
                        check("pool_col", int'(bus.pool_col), e.col);
                    end
                end else begin
                    stall_seen = 1'b1;
                    held_data  = bus.pool_data;
                    held_row   = bus.pool_row;
                    held_col   = bus.pool_col;
                end
            end else begin
                stall_seen = 1'b0;
            end
        end
    end

    // Downstream ready: optionally held low for 10 cycles at the start of each OUT.
    initial begin
        bus.pool_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_mode && bus.pool_valid) begin
                bus.pool_ready = 1'b0;
                repeat (10) begin
                    @(posedge clk);
                    #1;
                end
                bus.pool_ready = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic push4(input int a, input int b, input int c, input int d);
        sb.push_back('{a, 0, 0});
        sb.push_back('{b, 0, 1});
        sb.push_back('{c, 1, 0});
        sb.push_back('{d, 1, 1});
    endtask

    task automatic load_lin(input int base);
        for (int r = 0; r < CS; r++)
            for (int c = 0; c < CS; c++)
                mem[r][c] = DW'(base + 4 * r + c);
    endtask

    task automatic check_idle(input string name);
        check({name, "_rd_en"}, int'(bus.rd_en), 0);
        check({name, "_rd_addr"}, int'({bus.rd_row, bus.rd_col}), 0);
        check({name, "_pool_valid"}, int'(bus.pool_valid), 0);
        check({name, "_pool_data"}, int'(bus.pool_data), 0);
        check({name, "_pool_rc"}, int'({bus.pool_row, bus.pool_col}), 0);
        check({name, "_busy"}, int'(bus.busy), 0);
        check({name, "_done"}, int'(bus.done), 0);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!bus.done && n < 600) begin
            tick();
            n++;
        end
        check(name, int'(bus.done), 1);
    endtask

    task automatic run_frame(input string name, input int e0, input int e1,
                             input int e2, input int e3, input bit chk_lat);
        int d0;
        int r0;
        int lat;
        d0 = n_done;
        r0 = n_rd;
        push4(e0, e1, e2, e3);
        pulse_start();
        if (chk_lat) begin
            lat = 1;
            while (!bus.pool_valid && lat < 20) begin
                tick();
                lat++;
            end
            check({name, "_first_valid_cycle"}, lat, 6);
        end
        wait_done({name, "_done_seen"});
        check({name, "_busy_in_done"}, int'(bus.busy), 1);
        tick();
        check({name, "_idle_after"}, int'(bus.busy), 0);
        check({name, "_done_count"}, n_done - d0, 1);
        check({name, "_reads"}, n_rd - r0, 16);
        check({name, "_sb_empty"}, sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.start = 1'b0;
        reset     = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        check_idle("reset");

        // 1) ascending map
        load_lin(0);
        run_frame("s1", 5, 7, 13, 15, 1'b1);

        // 2) all-negative map
        load_lin(-100);
        run_frame("s2", -95, -93, -87, -85, 1'b0);

        // 3) ties and extreme negatives
        mem[0][0] = 16'sd7;  mem[0][1] = 16'sd7;  mem[1][0] = 16'sd7;  mem[1][1] = 16'sd7;
        mem[0][2] = -16'sd1; mem[0][3] = -16'sd1; mem[1][2] = 16'sh8000; mem[1][3] = -16'sd1;
        mem[2][0] = 16'sd3;  mem[2][1] = -16'sd5; mem[3][0] = 16'sd9;  mem[3][1] = 16'sd9;
        mem[2][2] = 16'sh8000; mem[2][3] = 16'sh8000; mem[3][2] = 16'sh8000; mem[3][3] = 16'sh8000;
        run_frame("s3", 7, -1, 9, -32768, 1'b0);

        // 4) backpressure in every OUT
        load_lin(0);
        stall_mode = 1'b1;
        run_frame("s4", 5, 7, 13, 15, 1'b0);
        stall_mode = 1'b0;

        // 5) reset during the third read of window (0,1)
        sb.push_back('{5, 0, 0});
        pulse_start();
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.rd_en) n++;
            if (n == 7) break;
            tick();
        end
        check("s5_reached_reset_point", n, 7);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle("s5_after_reset");
        repeat (20) tick();
        check("s5_no_spurious", sb.size(), 0);
        check("s5_still_idle", int'(bus.busy), 0);
        run_frame("s5_rerun", 5, 7, 13, 15, 1'b1);

        // 6) start while busy ignored; start right after DONE accepted
        n = n_done;
        push4(5, 7, 13, 15);
        pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done("s6_done_a");
        push4(5, 7, 13, 15);
        bus.start = 1'b1;
        tick();
        check("s6_start_in_done_ignored", int'(bus.busy), 0);
        tick();
        bus.start = 1'b0;
        check("s6_start_after_done_accepted", int'(bus.busy), 1);
        check("s6_first_frame_drained", sb.size(), 4);
        wait_done("s6_done_b");
        tick();
        check("s6_done_count", n_done - n, 2);
        check("s6_sb_empty", sb.size(), 0);
        repeat (10) tick();
        check("s6_final_idle", int'(bus.busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
